// File: rtl/cube_calc.sv
// cube_calc: sequential exact integer cube, y = a^3, built from a
// shift-add multiplier run twice (a*a, then (a*a)*a).
// Optional build macro: CUBE_CALC_EARLY_EXIT_EN -- when defined, each
// multiply phase stops as soon as the remaining multiplier bits are zero,
// so latency depends on the operand's bit length. Results are unchanged.
module cube_calc #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_bi,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [3*WIDTH-1:0]   y_bo
);

  localparam int AW    = 3 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQ,
    S_CUBE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [AW-1:0]      y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;

  // One shift-add step, shared by both multiply phases.
  logic [AW-1:0]      acc_step;
  logic [AW-1:0]      mcand_step;
  logic [WIDTH-1:0]   mplier_step;
  logic               last_step;

  // Datapath for a single shift-add step and the end-of-phase decision.
  always_comb begin
    acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_step  = mcand_q << 1;
    mplier_step = mplier_q >> 1;
`ifdef CUBE_CALC_EARLY_EXIT_EN
    // Remaining multiplier bits are all zero: further steps add nothing.
    // The counter bound still caps the phase at WIDTH steps.
    last_step   = (mplier_step == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
    last_step   = (cnt_q == CNT_W'(WIDTH - 1));
`endif
  end

  // Next-state and register-update logic for the control FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d      = a_bi;
          acc_d    = '0;
          mcand_d  = AW'(a_bi);
          mplier_d = a_bi;
          cnt_d    = '0;
          state_d  = S_SQ;
        end
      end

      S_SQ: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          // Square is complete; reuse the same engine for sq * a.
          acc_d    = '0;
          mcand_d  = AW'(acc_step[2*WIDTH-1:0]);
          mplier_d = a_q;
          cnt_d    = '0;
          state_d  = S_CUBE;
        end
      end

      S_CUBE: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        y_d     = acc_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset aborts any computation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign valid_o = valid_q;
  assign y_bo    = y_q;

endmodule

// File: tb/tb_cube_calc.sv
// tb_cube_calc: self-checking bench for cube_calc with a behavioural
// reference (plain a*a*a and a latency formula from operand bit length).
module tb_cube_calc;

  localparam int WIDTH = 8;

  logic               clk_i;
  logic               rst_i;
  logic               start_i;
  logic [WIDTH-1:0]   a_bi;
  logic               busy_o;
  logic               valid_o;
  logic [3*WIDTH-1:0] y_bo;

  int n_checks;
  int n_errors;

  cube_calc #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_bi    (a_bi),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .y_bo    (y_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] ref_cube(input logic [WIDTH-1:0] a);
    longint unsigned x;
    x = longint'(a);
    return x * x * x;
  endfunction

  function automatic int ref_latency(input logic [WIDTH-1:0] a);
    int bl;
    int v;
    bl = 0;
    v  = int'(a);
    while (v != 0) begin
      bl++;
      v = v >> 1;
    end
    if (bl < 1) bl = 1;
`ifdef CUBE_CALC_EARLY_EXIT_EN
    return 2 * bl + 1;
`else
    return 2 * WIDTH + 1;
`endif
  endfunction

  // Launches one request from the current (post-edge) time and waits for
  // valid_o. Optionally pulses start_i with a_bi=200 at cycle 'interf'.
  // Returns with time sitting in the valid_o cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input int interf,
                        output logic [3*WIDTH-1:0] y, output int lat,
                        output int busy_err);
    start_i  = 1'b1;
    a_bi     = a;
    tick();
    start_i  = 1'b0;
    a_bi     = WIDTH'($urandom);
    lat      = 0;
    busy_err = 0;
    if (!busy_o) busy_err++;
    while (lat < 200) begin
      tick();
      lat++;
      if (valid_o) begin
        if (busy_o) busy_err++;
        break;
      end
      if (!busy_o) busy_err++;
      if (lat == interf) begin
        start_i = 1'b1;
        a_bi    = 8'd200;
      end else begin
        start_i = 1'b0;
        a_bi    = WIDTH'($urandom);
      end
    end
    start_i = 1'b0;
    y       = y_bo;
  endtask

  logic [3*WIDTH-1:0] y;
  int                 lat;
  int                 lat2;
  int                 berr;
  int                 pulses;
  logic [WIDTH-1:0]   ra;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_i    = 1'b0;
    start_i  = 1'b0;
    a_bi     = '0;
    tick();
    tick();
    check("reset_busy",  64'(busy_o),  64'd0);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_y",     64'(y_bo),    64'd0);
    rst_i = 1'b1;
    tick();

    // Directed operands: zero, maximum, small.
    run_op(8'd0, -1, y, lat, berr);
    check("a0_y",   64'(y), ref_cube(8'd0));
    check("a0_lat", 64'(lat), 64'(ref_latency(8'd0)));
    tick();
    check("a0_pulse", 64'(valid_o), 64'd0);

    run_op(8'd255, -1, y, lat, berr);
    check("a255_y",   64'(y), 64'd16581375);
    check("a255_lat", 64'(lat), 64'd17);
    tick();

    run_op(8'd5, -1, y, lat, berr);
    check("a5_y",    64'(y), 64'd125);
    check("a5_lat",  64'(lat), 64'(ref_latency(8'd5)));
    check("a5_busy", 64'(berr), 64'd0);
    tick();

    // Start while busy must be ignored.
    run_op(8'd3, 4, y, lat, berr);
    check("busy_start_y",   64'(y), 64'd27);
    check("busy_start_lat", 64'(lat), 64'(ref_latency(8'd3)));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    check("busy_start_pulses", 64'(pulses), 64'd0);
    check("y_held", 64'(y_bo), 64'd27);

    // Asynchronous reset mid-operation aborts.
    start_i = 1'b1;
    a_bi    = 8'd7;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    rst_i = 1'b0;
    #1;
    check("abort_busy",  64'(busy_o),  64'd0);
    check("abort_y",     64'(y_bo),    64'd0);
    check("abort_valid", 64'(valid_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (valid_o) pulses++;
    end
    check("abort_no_valid", 64'(pulses), 64'd0);
    run_op(8'd2, -1, y, lat, berr);
    check("after_abort_y", 64'(y), 64'd8);
    tick();

    // Back-to-back: second start issued in the valid_o cycle.
    run_op(8'd4, -1, y, lat, berr);
    check("b2b_first_y", 64'(y), 64'd64);
    run_op(8'd6, -1, y, lat2, berr);
    check("b2b_second_y", 64'(y), 64'd216);
`ifdef CUBE_CALC_EARLY_EXIT_EN
    check("b2b_gap", 64'(lat2 + 1), 64'd8);
`else
    check("b2b_gap", 64'(lat2 + 1), 64'd18);
`endif
    tick();

    // Randomized operands against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom_range(0, 255));
      run_op(ra, -1, y, lat, berr);
      check("rand_y",    64'(y), ref_cube(ra));
      check("rand_lat",  64'(lat), 64'(ref_latency(ra)));
      check("rand_busy", 64'(berr), 64'd0);
      tick();
      check("rand_pulse", 64'(valid_o), 64'd0);
      check("rand_hold",  64'(y_bo), ref_cube(ra));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
